uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares a single `uart_tx` serializer among `N_REQ` byte producers. Each producer offers a byte and its parity configuration over a valid/ready handshake. The arbiter grants one producer, presents the byte to the serializer with a one-cycle `Data_Valid` strobe, and holds off further grants until the serializer's `Busy` has risen and fallen again. It sits between the system-side producers and the `uart_tx` instance in the TX subsystem top.

---
 rtl/uart_tx_arbiter_if.sv | 76 +++++++
 rtl/uart_tx_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter_if
//   Bundles the producer-side request bus and the serializer-side load bus of
//   the shared UART transmitter arbiter.
//
//   Producer side (per requester i, N_REQ lanes):
//     req_valid[i]    byte pending
//     req_data        byte i at bits [8i+7:8i]
//     req_par_en[i]   parity enable for that frame
//     req_par_typ[i]  parity type (0 even, 1 odd)
//     req_ready[i]    one-hot accept, transfer on valid & ready
//   Serializer side:
//     tx_busy         serializer Busy
//     tx_p_data       byte to serializer (P_DATA)
//     tx_data_valid   one-cycle load strobe (Data_Valid)
//     tx_par_en       frame parity enable
//     tx_par_typ      frame parity type
//   Status:
//     grant_id        index of the current or last granted requester
//     timeout_err     one-cycle pulse when Busy never rose after a strobe
//
//   master : producers + serializer (drive requests and Busy)
//   slave  : the arbiter
// -----------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
);

  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_par_en;
  logic [N_REQ-1:0]   req_par_typ;
  logic [N_REQ-1:0]   req_ready;

  logic               tx_busy;
  logic [7:0]         tx_p_data;
  logic               tx_data_valid;
  logic               tx_par_en;
  logic               tx_par_typ;

  logic [ID_W-1:0]    grant_id;
  logic               timeout_err;

  modport master (
    output req_valid,
    output req_data,
    output req_par_en,
    output req_par_typ,
    input  req_ready,
    output tx_busy,
    input  tx_p_data,
    input  tx_data_valid,
    input  tx_par_en,
    input  tx_par_typ,
    input  grant_id,
    input  timeout_err
  );

  modport slave (
    input  req_valid,
    input  req_data,
    input  req_par_en,
    input  req_par_typ,
    output req_ready,
    input  tx_busy,
    output tx_p_data,
    output tx_data_valid,
    output tx_par_en,
    output tx_par_typ,
    output grant_id,
    output timeout_err
  );

endinterface

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//   Round-robin arbiter sharing one uart_tx serializer among N_REQ byte
//   producers. A winner is accepted in ARB, its byte and parity settings are
//   latched, a one-cycle Data_Valid strobe is issued in LOAD, and no further
//   grant is made until the serializer Busy has risen and fallen again. If Busy
//   fails to rise within BUSY_TIMEOUT cycles the frame is dropped and
//   timeout_err pulses.
//
// Parameters:
//   N_REQ        number of requesters (2..8)
//   MAX_BURST    back-to-back frames one requester may win before rotation
//   BUSY_TIMEOUT cycles spent waiting for Busy to rise before aborting
//
// Ports:
//   CLK  clock, rising edge
//   RST  synchronous active-high reset
//   bus  uart_tx_arbiter_if.slave (request bus, serializer bus, status)
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int MAX_BURST    = 2,
  parameter int BUSY_TIMEOUT = 15
) (
  input  logic           CLK,
  input  logic           RST,
  uart_tx_arbiter_if.slave bus
);

  localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);
  localparam int BC_W  = $clog2(MAX_BURST + 1);

  localparam logic [1:0] ST_ARB       = 2'd0;
  localparam logic [1:0] ST_LOAD      = 2'd1;
  localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  logic [1:0]       state;
  logic [7:0]       p_data_q;
  logic             par_en_q;
  logic             par_typ_q;
  logic             data_valid_q;
  logic [ID_W-1:0]  grant_q;
  logic [BC_W-1:0]  burst_cnt;
  logic             have_grant;
  logic [CNT_W-1:0] to_cnt;
  logic             timeout_q;

  // ---------------------------------------------------------------------------
  // Winner selection
  // ---------------------------------------------------------------------------
  logic             keep;
  logic             found;
  logic [ID_W-1:0]  srch_id;
  logic [ID_W-1:0]  winner;
  logic             accept;
  logic [N_REQ-1:0] ready;
  logic [7:0]       win_data;
  logic             win_par_en;
  logic             win_par_typ;
  int unsigned      cand;
  int unsigned      win_idx;

  always_comb begin
    keep        = 1'b0;
    found       = 1'b0;
    srch_id     = grant_q;
    winner      = grant_q;
    accept      = 1'b0;
    ready       = '0;
    win_data    = '0;
    win_par_en  = 1'b0;
    win_par_typ = 1'b0;
    cand        = 0;
    win_idx     = 0;

    // Reset leaves grant_id at N_REQ-1 purely so the round-robin search starts
    // at requester 0; have_grant stops that reset value from counting as a
    // real previous grant that could be extended as a burst.
    keep = have_grant && bus.req_valid[grant_q] &&
           (burst_cnt < BC_W'(MAX_BURST - 1));

    // Search grant_id+1 .. grant_id+N_REQ (mod N_REQ); the previous grantee is
    // visited last, so it still wins when it is the only one valid.
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = (32'(grant_q) + k) % N_REQ;
      if (!found && bus.req_valid[cand]) begin
        found   = 1'b1;
        srch_id = ID_W'(cand);
      end
    end

    winner = keep ? grant_q : srch_id;

    accept = (state == ST_ARB) && !RST && !bus.tx_busy && (|bus.req_valid);

    if (accept) begin
      ready[winner] = 1'b1;
    end

    win_idx     = 32'(winner);
    win_data    = bus.req_data[8*win_idx +: 8];
    win_par_en  = bus.req_par_en[win_idx];
    win_par_typ = bus.req_par_typ[win_idx];
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= ST_ARB;
      p_data_q     <= '0;
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      data_valid_q <= 1'b0;
      grant_q      <= ID_W'(N_REQ - 1);
      burst_cnt    <= '0;
      have_grant   <= 1'b0;
      to_cnt       <= '0;
      timeout_q    <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      timeout_q    <= 1'b0;

      case (state)
        ST_ARB: begin
          if (accept) begin
            p_data_q     <= win_data;
            par_en_q     <= win_par_en;
            par_typ_q    <= win_par_typ;
            grant_q      <= winner;
            have_grant   <= 1'b1;
            // A win through the rotation search starts a fresh burst window,
            // even when the search lands back on the same requester.
            burst_cnt    <= keep ? (burst_cnt + 1'b1) : '0;
            data_valid_q <= 1'b1;
            state        <= ST_LOAD;
          end
        end

        ST_LOAD: begin
          to_cnt <= '0;
          state  <= ST_WAIT_BUSY;
        end

        ST_WAIT_BUSY: begin
          // Busy is tested before the expiry, so a rise on the last allowed
          // cycle is still a successful hand-off.
          if (bus.tx_busy) begin
            state <= ST_WAIT_DONE;
          end else if (to_cnt == CNT_W'(BUSY_TIMEOUT - 1)) begin
            timeout_q <= 1'b1;
            state     <= ST_ARB;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        ST_WAIT_DONE: begin
          if (!bus.tx_busy) begin
            state <= ST_ARB;
          end
        end

        default: begin
          state <= ST_ARB;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.req_ready     = ready;
  assign bus.tx_p_data     = p_data_q;
  assign bus.tx_par_en     = par_en_q;
  assign bus.tx_par_typ    = par_typ_q;
  assign bus.tx_data_valid = data_valid_q;
  assign bus.grant_id      = grant_q;
  assign bus.timeout_err   = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//   Two arbiter instances: dut_a (MAX_BURST=2) for vectors, burst, timeout,
//   collision and reset cases; dut_b (MAX_BURST=1) for strict rotation.
//   Expected frames are queued when stimulus is applied and popped on every
//   Data_Valid strobe.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N_REQ(N)) bus_a ();
  uart_tx_arbiter_if #(.N_REQ(N)) bus_b ();

  uart_tx_arbiter #(.N_REQ(N), .MAX_BURST(2), .BUSY_TIMEOUT(15)) dut_a (
    .CLK (clk),
    .RST (rst),
    .bus (bus_a)
  );

  uart_tx_arbiter #(.N_REQ(N), .MAX_BURST(1), .BUSY_TIMEOUT(15)) dut_b (
    .CLK (clk),
    .RST (rst),
    .bus (bus_b)
  );

  // Producer data, fixed per requester
  logic [7:0]   data_c [N] = '{8'h11, 8'h22, 8'hA5, 8'h44};
  logic [N-1:0] pe_c = 4'b0101;
  logic [N-1:0] pt_c = 4'b0110;

  logic [N-1:0] valid_a = '0;
  logic [N-1:0] valid_b = '0;
  logic [N-1:0] drop_a  = '0;

  assign bus_a.req_valid   = valid_a;
  assign bus_b.req_valid   = valid_b;
  assign bus_a.req_data    = {data_c[3], data_c[2], data_c[1], data_c[0]};
  assign bus_b.req_data    = {data_c[3], data_c[2], data_c[1], data_c[0]};
  assign bus_a.req_par_en  = pe_c;
  assign bus_b.req_par_en  = pe_c;
  assign bus_a.req_par_typ = pt_c;
  assign bus_b.req_par_typ = pt_c;

  // Serializer models: Busy high for 4 cycles starting the cycle after the
  // strobe. dut_a can be switched to a manually driven Busy.
  logic       auto_a = 1'b0;
  logic       man_a  = 1'b0;
  logic [3:0] bc_a   = '0;
  logic [3:0] bc_b   = '0;

  always @(posedge clk) begin
    if (bus_a.tx_data_valid) bc_a <= 4'd4;
    else if (bc_a != 0)      bc_a <= bc_a - 4'd1;
  end
  always @(posedge clk) begin
    if (bus_b.tx_data_valid) bc_b <= 4'd4;
    else if (bc_b != 0)      bc_b <= bc_b - 4'd1;
  end

  assign bus_a.tx_busy = auto_a ? (bc_a != 0) : man_a;
  assign bus_b.tx_busy = (bc_b != 0);

  // Scoreboard
  typedef struct {
    int         id;
    logic [7:0] d;
    logic       pe;
    logic       pt;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  int total = 0;
  int bad   = 0;
  int n_strobe_a = 0;
  int n_strobe_b = 0;
  logic rose_b = 1'b0;

  // Values sampled at the last negedge
  logic [N-1:0] smp_ready_a;
  logic         smp_dv_a;
  logic         smp_terr_a;
  logic [1:0]   smp_grant_a;
  logic [7:0]   smp_pdata_a;
  logic         smp_pe_a;
  logic         smp_pt_a;

  function automatic exp_t mk(int id);
    exp_t e;
    e.id = id;
    e.d  = data_c[id];
    e.pe = pe_c[id];
    e.pt = pt_c[id];
    return e;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_a(int id);
    q_a.push_back(mk(id));
  endtask

  task automatic push_b(int id);
    q_b.push_back(mk(id));
  endtask

  // Sample at negedge, score strobes, then advance to just past the posedge
  // and retire accepted requesters listed in drop_a.
  task automatic step();
    logic [N-1:0] acc_a;
    exp_t e;
    @(negedge clk);
    smp_ready_a = bus_a.req_ready;
    smp_dv_a    = bus_a.tx_data_valid;
    smp_terr_a  = bus_a.timeout_err;
    smp_grant_a = bus_a.grant_id;
    smp_pdata_a = bus_a.tx_p_data;
    smp_pe_a    = bus_a.tx_par_en;
    smp_pt_a    = bus_a.tx_par_typ;
    acc_a       = bus_a.req_ready & valid_a;

    if (bus_a.tx_data_valid) begin
      n_strobe_a++;
      check("strobe_idle_a", 32'(bus_a.tx_busy), 0);
      if (q_a.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_a: unexpected strobe grant=%0d expected none", bus_a.grant_id);
      end else begin
        e = q_a.pop_front();
        check("sb_a_grant", 32'(bus_a.grant_id), e.id);
        check("sb_a_data", 32'(bus_a.tx_p_data), 32'(e.d));
        check("sb_a_par_en", 32'(bus_a.tx_par_en), 32'(e.pe));
        check("sb_a_par_typ", 32'(bus_a.tx_par_typ), 32'(e.pt));
      end
    end

    if (bus_b.tx_busy) rose_b = 1'b1;
    if (bus_b.tx_data_valid) begin
      if (n_strobe_b > 0) check("sb_b_one_per_busy", 32'(rose_b), 1);
      rose_b = 1'b0;
      n_strobe_b++;
      if (q_b.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_b: unexpected strobe grant=%0d expected none", bus_b.grant_id);
      end else begin
        e = q_b.pop_front();
        check("sb_b_grant", 32'(bus_b.grant_id), e.id);
        check("sb_b_data", 32'(bus_b.tx_p_data), 32'(e.d));
      end
    end

    @(posedge clk);
    #1;
    valid_a = valid_a & ~(acc_a & drop_a);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic run(int na, int nb, int budget);
    int sa;
    int sb;
    int cyc;
    sa  = n_strobe_a;
    sb  = n_strobe_b;
    cyc = 0;
    while (((n_strobe_a - sa) < na || (n_strobe_b - sb) < nb) && cyc < budget) begin
      step();
      cyc++;
    end
    check("run_budget", 32'(cyc < budget), 1);
  endtask

  // Table of single-accept vectors applied straight after reset
  typedef struct {
    logic [N-1:0] valid;
    logic         busy;
    logic [N-1:0] exp_ready;
    int           exp_id;
  } vec_t;

  vec_t vecs [7];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    int seen;

    vecs[0] = '{valid: 4'b0000, busy: 1'b0, exp_ready: 4'b0000, exp_id: -1};
    vecs[1] = '{valid: 4'b0100, busy: 1'b0, exp_ready: 4'b0100, exp_id: 2};
    vecs[2] = '{valid: 4'b1111, busy: 1'b0, exp_ready: 4'b0001, exp_id: 0};
    vecs[3] = '{valid: 4'b1000, busy: 1'b0, exp_ready: 4'b1000, exp_id: 3};
    vecs[4] = '{valid: 4'b1010, busy: 1'b0, exp_ready: 4'b0010, exp_id: 1};
    vecs[5] = '{valid: 4'b1111, busy: 1'b1, exp_ready: 4'b0000, exp_id: -1};
    vecs[6] = '{valid: 4'b0110, busy: 1'b0, exp_ready: 4'b0010, exp_id: 1};

    // Power-on reset, with requests already present during reset
    step();
    valid_a = '1;
    rst = 1'b1;
    step();
    check("rst_ready_gated", 32'(smp_ready_a), 0);
    step();
    rst = 1'b0;
    valid_a = '0;
    step();
    check("rst_pdata", 32'(smp_pdata_a), 0);
    check("rst_par_en", 32'(smp_pe_a), 0);
    check("rst_par_typ", 32'(smp_pt_a), 0);
    check("rst_dv", 32'(smp_dv_a), 0);
    check("rst_grant", 32'(smp_grant_a), 3);
    check("rst_terr", 32'(smp_terr_a), 0);

    // Vector table
    for (int unsigned i = 0; i < 7; i++) begin
      do_reset();
      man_a   = vecs[i].busy;
      valid_a = vecs[i].valid;
      if (vecs[i].exp_id >= 0) push_a(vecs[i].exp_id);
      step();
      check("vec_ready", 32'(smp_ready_a), 32'(vecs[i].exp_ready));
      valid_a = '0;
      step();
      check("vec_strobe", 32'(smp_dv_a), 32'(vecs[i].exp_id >= 0));
      check("vec_queue_empty", q_a.size(), 0);
    end
    man_a = 1'b0;
    repeat (6) step();

    // Burst, MAX_BURST=2
    auto_a = 1'b1;
    do_reset();
    foreach (data_c[i]) begin
      push_a(i);
      push_a(i);
    end
    valid_a = '1;
    run(8, 0, 300);
    valid_a = '0;
    check("burst_queue_empty", q_a.size(), 0);

    // Burst with requester 1 leaving after its first frame
    do_reset();
    push_a(0); push_a(0); push_a(1); push_a(2); push_a(2);
    drop_a  = 4'b0010;
    valid_a = '1;
    run(5, 0, 300);
    valid_a = '0;
    drop_a  = '0;
    check("burst_drop_queue_empty", q_a.size(), 0);

    // Strict rotation on the MAX_BURST=1 instance
    do_reset();
    push_b(0); push_b(1); push_b(2); push_b(3); push_b(0);
    valid_b = '1;
    run(0, 5, 300);
    valid_b = '0;
    check("rotation_queue_empty", q_b.size(), 0);
    repeat (8) step();

    // Busy timeout: Busy never rises
    auto_a = 1'b0;
    man_a  = 1'b0;
    do_reset();
    push_a(0); push_a(1);
    drop_a  = 4'b0011;
    valid_a = 4'b0011;
    run(1, 0, 20);
    k = 0;
    do begin
      step();
      k++;
    end while (!smp_terr_a && k < 40);
    check("timeout_cycle", k, 16);
    check("timeout_next_ready", 32'(smp_ready_a), 32'(4'b0010));
    step();
    check("timeout_one_cycle", 32'(smp_terr_a), 0);
    step();
    check("timeout_queue_empty", q_a.size(), 0);
    valid_a = '0;
    drop_a  = '0;

    // Busy rises on the expiry cycle
    do_reset();
    push_a(0); push_a(1);
    drop_a  = 4'b0011;
    valid_a = 4'b0011;
    run(1, 0, 20);
    repeat (14) step();
    man_a = 1'b1;
    seen = 0;
    for (int unsigned j = 0; j < 20; j++) begin
      step();
      if (smp_terr_a || smp_ready_a != 0) seen++;
    end
    check("collision_no_err_no_grant", seen, 0);
    man_a = 1'b0;
    run(1, 0, 20);
    check("collision_queue_empty", q_a.size(), 0);
    valid_a = '0;
    drop_a  = '0;

    // Reset while in WAIT_DONE with Busy still high
    do_reset();
    push_a(0);
    drop_a  = 4'b0001;
    valid_a = 4'b0001;
    run(1, 0, 20);
    man_a = 1'b1;
    step();
    step();
    rst = 1'b1;
    valid_a = '1;
    step();
    check("midrst_ready_gated", 32'(smp_ready_a), 0);
    rst = 1'b0;
    step();
    check("midrst_pdata", 32'(smp_pdata_a), 0);
    check("midrst_par_en", 32'(smp_pe_a), 0);
    check("midrst_par_typ", 32'(smp_pt_a), 0);
    check("midrst_grant", 32'(smp_grant_a), 3);
    check("midrst_dv", 32'(smp_dv_a), 0);
    check("midrst_terr", 32'(smp_terr_a), 0);
    check("midrst_busy_hold", 32'(smp_ready_a), 0);
    seen = 0;
    for (int unsigned j = 0; j < 4; j++) begin
      step();
      if (smp_ready_a != 0) seen++;
    end
    check("midrst_no_grant_busy", seen, 0);
    man_a = 1'b0;
    push_a(0);
    step();
    check("midrst_first_grant", 32'(smp_ready_a), 32'(4'b0001));
    valid_a = '0;
    drop_a  = '0;
    step();
    check("midrst_queue_empty", q_a.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
